// File: rtl/mod_n_adjustable_counter.sv
// Modulo-N clock digit with tick-driven run mode and debounced, auto-repeating
// up/down adjustment. Carry pulses chain into the next digit's tick_in.

module mod_n_adjustable_counter_btn #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic Reset_N,
    input  logic i_raw,
    input  logic i_other_level,
    output logic o_level,
    output logic o_step
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW      = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } rpt_state_t;

    logic [1:0]    r_sync;
    logic          r_level;
    logic [DW-1:0] r_db_cnt;
    rpt_state_t    r_state;
    rpt_state_t    w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic          w_step;

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_sync   <= '0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] != r_level) begin
                if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level  <= r_sync[1];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // Timer value k in the cycle t0+k; IDLE with the level high is the rising-edge cycle.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_step       = 1'b0;
        if (!r_level) begin
            w_state_next = S_IDLE;
            w_timer_next = '0;
        end else if (i_other_level) begin
            w_state_next = S_DELAY;
            w_timer_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_step       = 1'b1;
                    w_state_next = S_DELAY;
                    w_timer_next = TW'(1);
                end
                S_DELAY: begin
                    if (r_timer == TW'(REPEAT_DELAY)) begin
                        w_step       = 1'b1;
                        w_state_next = S_REPEAT;
                        w_timer_next = TW'(1);
                    end else begin
                        w_timer_next = r_timer + TW'(1);
                    end
                end
                S_REPEAT: begin
                    if (r_timer == TW'(REPEAT_PERIOD)) begin
                        w_step       = 1'b1;
                        w_timer_next = TW'(1);
                    end else begin
                        w_timer_next = r_timer + TW'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_timer_next = '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_step  = w_step;

endmodule

module mod_n_adjustable_counter #(
    parameter int MODULUS         = 60,
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             Reset_N,
    input  logic             tick_in,
    input  logic             set_mode,
    input  logic             add_btn,
    input  logic             sub_btn,
    output logic [WIDTH-1:0] count,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic             w_add_level;
    logic             w_sub_level;
    logic             w_add_step;
    logic             w_sub_step;
    logic [WIDTH-1:0] r_count;
    logic             r_carry;

    // Each button sees the other's debounced level so a simultaneous hold cancels both.
    mod_n_adjustable_counter_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_add (
        .clk          (clk),
        .Reset_N      (Reset_N),
        .i_raw        (add_btn),
        .i_other_level(w_sub_level),
        .o_level      (w_add_level),
        .o_step       (w_add_step)
    );

    mod_n_adjustable_counter_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_sub (
        .clk          (clk),
        .Reset_N      (Reset_N),
        .i_raw        (sub_btn),
        .i_other_level(w_add_level),
        .o_level      (w_sub_level),
        .o_step       (w_sub_step)
    );

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (set_mode) begin
                if (w_add_step) begin
                    r_count <= (r_count == LAST) ? '0 : r_count + WIDTH'(1);
                end else if (w_sub_step) begin
                    r_count <= (r_count == '0) ? LAST : r_count - WIDTH'(1);
                end
            end else if (tick_in) begin
                if (r_count == LAST) begin
                    r_count <= '0;
                    r_carry <= 1'b1;
                end else begin
                    r_count <= r_count + WIDTH'(1);
                end
            end
        end
    end

    assign count     = r_count;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_mod_n_adjustable_counter.sv
// Scoreboard bench for mod_n_adjustable_counter: a mod-60 and a mod-24 instance,
// stimulus queues per-cycle expectations, a negedge monitor compares them.

module tb_mod_n_adjustable_counter;

    localparam int M0 = 60;
    localparam int M1 = 24;

    logic       clk;
    logic [1:0] rstn, tick, mode, addb, subb;
    logic [5:0] count0;
    logic [4:0] count1;
    logic       carry0, carry1;

    int cyc;
    int checks;
    int errors;
    int exp_cnt [2];

    typedef struct {
        int    d;
        int    cyc;
        int    cnt;
        logic  cy;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   act_cnt;
    logic act_cy;

    mod_n_adjustable_counter #(
        .MODULUS(M0), .WIDTH(6), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut60 (
        .clk(clk), .Reset_N(rstn[0]), .tick_in(tick[0]), .set_mode(mode[0]),
        .add_btn(addb[0]), .sub_btn(subb[0]), .count(count0), .carry_out(carry0)
    );

    mod_n_adjustable_counter #(
        .MODULUS(M1), .WIDTH(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut24 (
        .clk(clk), .Reset_N(rstn[1]), .tick_in(tick[1]), .set_mode(mode[1]),
        .add_btn(addb[1]), .sub_btn(subb[1]), .count(count1), .carry_out(carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e       = sb.pop_front();
            act_cnt = (e.d == 0) ? int'(count0) : int'(count1);
            act_cy  = (e.d == 0) ? carry0 : carry1;
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s dut%0d: check for cycle %0d missed (now %0d)", e.nm, e.d, e.cyc, cyc);
            end else if (act_cnt != e.cnt || act_cy !== e.cy) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: got count=%0d carry=%b, expected count=%0d carry=%b",
                         e.nm, e.d, cyc, act_cnt, act_cy, e.cnt, e.cy);
            end
        end
    end

    function automatic void push(input int d, input int c, input int cnt, input logic cy, input string nm);
        exp_t x;
        x.d = d; x.cyc = c; x.cnt = cnt; x.cy = cy; x.nm = nm;
        sb.push_back(x);
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i < hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] b(input int k);
        return rng(k, k + 1);
    endfunction

    function automatic int modn(input int d);
        return (d == 0) ? M0 : M1;
    endfunction

    // Single-cycle tick pulses for a full revolution, then ticks on every cycle for two.
    task automatic tick_test(input int d);
        int m;
        m = modn(d);
        mode[d] = 1'b0;
        for (int i = 1; i <= m; i++) begin
            tick[d] = 1'b1;
            push(d, cyc + 1, i % m, (i == m), "tick_pulse");
            @(negedge clk);
            tick[d] = 1'b0;
            push(d, cyc + 1, i % m, 1'b0, "tick_gap");
            @(negedge clk);
        end
        for (int j = 1; j <= 2 * m; j++) begin
            tick[d] = 1'b1;
            push(d, cyc + 1, j % m, (j % m == 0), "tick_held");
            @(negedge clk);
        end
        tick[d] = 1'b0;
        exp_cnt[d] = 0;
    endtask

    // Bit k of each pattern is the input driven at window index k; index k is checked
    // one clock later. A raw button edge at index k shows up as a step at index k+6.
    task automatic vec(input int d, input string nm, input int len, input logic md,
                       input logic [63:0] addp, input logic [63:0] subp, input logic [63:0] tickp,
                       input logic [63:0] upp, input logic [63:0] dnp);
        int   m;
        int   ec;
        logic cy;
        m = modn(d);
        mode[d] = md;
        for (int k = 0; k < len; k++) begin
            addb[d] = addp[k];
            subb[d] = subp[k];
            tick[d] = tickp[k];
            ec = exp_cnt[d];
            cy = 1'b0;
            if (!md && tickp[k]) begin
                if (ec == m - 1) begin
                    ec = 0;
                    cy = 1'b1;
                end else begin
                    ec = ec + 1;
                end
            end
            if (upp[k]) ec = (ec + 1) % m;
            if (dnp[k]) ec = (ec + m - 1) % m;
            exp_cnt[d] = ec;
            push(d, cyc + 1, ec, cy, nm);
            @(negedge clk);
        end
        tick[d] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        rstn = '0; tick = '0; mode = '0; addb = '0; subb = '0;
        repeat (3) @(negedge clk);
        push(0, cyc + 1, 0, 1'b0, "reset");
        push(1, cyc + 1, 0, 1'b0, "reset");
        @(negedge clk);
        rstn = '1;
        @(negedge clk);

        tick_test(0);
        vec(0, "adj_sub_wrap", 18, 1'b1, '0, rng(0, 8), '0, '0, b(6));
        vec(0, "adj_add_wrap", 18, 1'b1, rng(0, 8), '0, '0, b(6), '0);
        vec(0, "bounce", 36, 1'b1, 64'h333 | rng(12, 22), '0, '0, b(18), '0);
        vec(0, "run_to_57", 58, 1'b0, '0, '0, rng(0, 56), '0, '0);
        vec(0, "auto_repeat", 50, 1'b1, rng(0, 40), '0, '0, b(6) | b(26) | b(31) | b(36) | b(41), '0);
        vec(0, "both_held", 40, 1'b1, rng(0, 30), rng(0, 30), '0, '0, '0);
        vec(0, "run_add_held", 40, 1'b0, rng(0, 30), '0, b(10), '0, '0);
        vec(0, "adj_ticks", 10, 1'b1, '0, '0, rng(2, 5), '0, '0);
        vec(0, "pre_reset", 29, 1'b1, rng(0, 29), '0, '0, b(6) | b(26), '0);

        // Reset lands mid-cycle with add still held; outputs must clear before the next edge.
        @(posedge clk);
        #2 rstn[0] = 1'b0;
        push(0, cyc, 0, 1'b0, "async_reset");
        @(negedge clk);
        push(0, cyc + 1, 0, 1'b0, "in_reset");
        @(negedge clk);
        rstn[0] = 1'b1;
        exp_cnt[0] = 0;
        vec(0, "post_reset", 44, 1'b1, rng(0, 34), '0, '0, b(6) | b(26) | b(31) | b(36), '0);

        tick_test(1);
        vec(1, "m24_sub_wrap", 18, 1'b1, '0, rng(0, 8), '0, '0, b(6));
        vec(1, "m24_add_wrap", 18, 1'b1, rng(0, 8), '0, '0, b(6), '0);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", sb.size());
            errors = errors + sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_n_adjustable_counter.md
# mod_n_adjustable_counter

Parametrised modulo-N clock-digit counter with debounced up/down adjustment, auto-repeat and carry output. It replaces fixed mod-60 counters in the clock chain: seconds/minutes use MODULUS=60, hours use MODULUS=24. All state is synchronous to one system clock. Carry pulses from each stage drive the next stage's `tick_in`.

## Interface
Parameters:
- MODULUS, 60, count range 0..MODULUS-1; must be ≥2
- WIDTH, 6, count width; must be ≥ clog2(MODULUS)
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must stay stable before it is accepted (20 ms at 50 MHz)
- REPEAT_DELAY, 25000000, cycles from an accepted press to the first auto-repeat step
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat steps

Ports:
- clk  in  1  system clock (50 MHz), rising edge
- Reset_N  in  1  reset, asynchronous, active-low
- tick_in  in  1  one-cycle count-enable pulse from the previous stage, synchronous to clk
- set_mode  in  1  1 = adjust mode (buttons active, ticks ignored); 0 = run mode
- add_btn  in  1  raw asynchronous increment button, active-high
- sub_btn  in  1  raw asynchronous decrement button, active-high
- count  out  WIDTH  current value, registered
- carry_out  out  1  one-cycle pulse when a tick wraps MODULUS-1 to 0, registered

## Operation
- Reset values: count=0, carry_out=0, synchronisers=0, debounced levels=0, debounce and repeat counters=0.
- Button path, per button:
  - 2-FF synchroniser, then debounce counter.
  - The debounced level updates only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old level clears the counter.
- Step generation, per button:
  - Step pulse on the debounced rising edge (t0).
  - While the debounced level stays high: steps at t0+REPEAT_DELAY, then every REPEAT_PERIOD.
  - A debounced fall stops repeat and clears the repeat timer.
- Button conflicts: if both debounced levels are high in a cycle, no step is issued and both repeat timers are held cleared.
- Run mode (set_mode=0):
  - tick_in increments count.
  - If count==MODULUS-1, count←0 and carry_out=1 for that cycle; otherwise carry_out=0.
  - Button steps are discarded. Debouncers keep running.
- Adjust mode (set_mode=1):
  - tick_in is discarded and carry_out stays 0.
  - An add step gives count←(count==MODULUS-1)?0:count+1.
  - A sub step gives count←(count==0)?MODULUS-1:count-1.
  - Adjustment never produces carry or borrow.
- set_mode is sampled every cycle. A step is applied only if set_mode=1 in the cycle the step pulse occurs.
- Invariant: count ≤ MODULUS-1 in every cycle. No intermediate out-of-range value is ever visible (e.g. 63).

## Timing
- tick_in high at edge n: count and carry_out are updated at edge n+1. carry_out is high in the same cycle count first shows 0.
- Button press latency, from raw stable high to the count change: 2 (sync) + DEBOUNCE_CYCLES + 1 (step register) cycles.
- Release latency: 2 + DEBOUNCE_CYCLES cycles before the repeat stops.
- Reset_N low clears all state immediately, independent of clk. Deassertion should be synchronised externally.
  - After release, a button still held is treated as a fresh press: exactly one step after the debounce interval, then normal repeat.
- Back-to-back tick_in on every cycle is legal. count advances each cycle and carry_out pulses once per MODULUS ticks.

## Test plan
Bench parameters unless stated: MODULUS=60, WIDTH=6, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
1. Reset, set_mode=0, then 60 single-cycle tick_in pulses → count 1..59 then 0; carry_out exactly one pulse, coincident with count=0. Repeat with tick_in held high for 120 cycles → two carries.
2. set_mode=1, count=0, clean sub press held 8 cycles → count=59, carry_out=0. Then a clean add press → count=0.
3. add_btn toggles every 2 cycles for 12 cycles, then stays high 10 cycles, then low → exactly one step, issued 2+4+1 cycles after the stable high begins.
4. Auto-repeat: debounced add high for cycles t0..t0+39 from count=57 → steps at t0, +20, +25, +30, +35 → count 58,59,0,1,2; carry_out stays 0.
5. Both buttons held together in adjust mode → count unchanged. In run mode with add held and ticks applied → only ticks count. In set_mode=1, tick pulses → count unchanged, no carry.
6. Reset_N pulsed low during the add repeat (count=5) → count=0 and carry_out=0 immediately. After release with add still held → one step at 2+4+1 cycles, then repeat resumes 20 cycles later. Rerun cases 1 and 2 with MODULUS=24, WIDTH=5 → wrap at 23↔0.
